// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_DETECT_EN: a zero divisor completes in one cycle and raises div_by_zero.
module restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, d_q;
  logic [WIDTH:0]    r_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  quotient_q, remainder_q;
  logic              dbz_q;

  logic              accept, zero_fast, last_iter;
  logic [WIDTH:0]    r_shift, trial, r_iter;
  logic [WIDTH-1:0]  q_iter;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  assign accept    = start && (state_q != StRun);
  assign last_iter = (state_q == StRun) && (cnt_q == CntW'(1));

  // One restoring step: shift {R,Q} left, keep the trial difference only when it did not borrow.
  always_comb begin
    r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
    if (!trial[WIDTH]) begin
      r_iter = trial;
      q_iter = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_iter = r_shift;
      q_iter = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = zero_fast ? StDone : StRun;
      StRun:  if (last_iter) state_d = StDone;
      StDone: begin
        if (start) state_d = zero_fast ? StDone : StRun;
        else       state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      q_q   <= dividend;
      d_q   <= divisor;
      r_q   <= '0;
      cnt_q <= CntW'(WIDTH);
      if (zero_fast) begin
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end
    end else if (state_q == StRun) begin
      q_q   <= q_iter;
      r_q   <= r_iter;
      cnt_q <= cnt_q - CntW'(1);
      if (last_iter) begin
        quotient_q  <= q_iter;
        remainder_q <= r_iter[WIDTH-1:0];
        dbz_q       <= 1'b0;
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
